// File: rtl/data_memory.sv
// Single-port, byte-writable, write-first block RAM with a registered read port.
// Reset clears only the output register; the array contents survive reset.
module data_memory #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                   clka,
  input  logic                   rsta,
  input  logic                   ena,
  input  logic [DATA_BITS/8-1:0] wea,
  input  logic [31:0]            addra,
  input  logic [DATA_BITS-1:0]   dina,
  output logic [DATA_BITS-1:0]   douta
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam int unsigned NBYTES = DATA_BITS / 8;

  // Zero contents at configuration; this is a power-up value, not a reset.
  logic [DATA_BITS-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_BITS-1:0] douta_q;
  logic [DATA_BITS-1:0] douta_d;
  logic [ADDR_BITS-1:0] addr_idx;
  logic                 unused_addr_hi;

  // Upper address bits are ignored so addresses wrap modulo DEPTH.
  assign addr_idx       = addra[ADDR_BITS-1:0];
  assign unused_addr_hi = &{1'b0, addra[31:ADDR_BITS]};

  // Write-first merge: enabled lanes take new data, others keep stored bytes.
  always_comb begin
    douta_d = mem_q[addr_idx];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (wea[i]) begin
        douta_d[8*i +: 8] = dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clka) begin
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (ena && wea[i]) begin
        mem_q[addr_idx][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      douta_q <= '0;
    end else if (ena) begin
      douta_q <= douta_d;
    end
  end

  assign douta = douta_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: each step applies one edge
// of stimulus and checks douta against a hand-computed value.
module tb_data_memory;

  logic        clka;
  logic        rsta;
  logic        ena;
  logic [3:0]  wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;

  int unsigned errors = 0;
  int unsigned checks = 0;

  data_memory #(
    .ADDR_BITS(10),
    .DATA_BITS(32)
  ) dut (
    .clka (clka),
    .rsta (rsta),
    .ena  (ena),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .douta(douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic rst, input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp, input string tag);
    @(negedge clka);
    rsta  = rst;
    ena   = en;
    wea   = we;
    addra = addr;
    dina  = din;
    @(posedge clka);
    #1;
    checks++;
    assert (douta === exp) else begin
      errors++;
      $error("FAIL %s: douta=%08h expected=%08h", tag, douta, exp);
    end
  endtask

  initial begin
    rsta  = 1'b1;
    ena   = 1'b0;
    wea   = 4'h0;
    addra = '0;
    dina  = '0;

    cyc(1'b1, 1'b0, 4'h0, 32'd0, 32'd0, 32'h0, "reset_state");
    cyc(1'b0, 1'b1, 4'h0, 32'd9, 32'hFFFF_FFFF, 32'h0, "powerup_zero");

    // Full word write then repeated reads
    cyc(1'b0, 1'b1, 4'hF, 32'd0, 32'd54, 32'd54, "full_write_first");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'hFFFF_FFFF, 32'd54, "read_after_write");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'd0, 32'd54, "read_again");

    // Reset clears douta but not the array
    cyc(1'b1, 1'b1, 4'h0, 32'd0, 32'd0, 32'h0, "reset_pulse");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'd0, 32'd54, "after_reset_read");

    // Byte lanes
    cyc(1'b0, 1'b1, 4'h1, 32'd0, 32'hFFFF_FFAB, 32'h0000_00AB, "lane0_write");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'd0, 32'h0000_00AB, "lane0_read");
    cyc(1'b0, 1'b1, 4'h8, 32'd0, 32'h1200_0000, 32'h1200_00AB, "lane3_write");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'd0, 32'h1200_00AB, "lane3_read");
    cyc(1'b0, 1'b1, 4'h6, 32'd0, 32'h5566_7788, 32'h1266_77AB, "lane12_write");

    // Enable gating: neither douta nor memory changes
    cyc(1'b0, 1'b0, 4'hF, 32'd5, 32'hDEAD_BEEF, 32'h1266_77AB, "ena0_hold");
    cyc(1'b0, 1'b0, 4'h0, 32'd7, 32'h0, 32'h1266_77AB, "ena0_hold2");
    cyc(1'b0, 1'b1, 4'h0, 32'd5, 32'h0, 32'h0, "ena0_no_write");

    // Write on a reset edge still lands in memory
    cyc(1'b1, 1'b1, 4'hF, 32'd6, 32'h1122_3344, 32'h0, "reset_with_write");
    cyc(1'b0, 1'b1, 4'h0, 32'd6, 32'h0, 32'h1122_3344, "reset_write_kept");

    // Address wrap-around
    cyc(1'b0, 1'b1, 4'hF, 32'd1024, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "wrap_write");
    cyc(1'b0, 1'b1, 4'h0, 32'd0, 32'h0, 32'hA5A5_A5A5, "wrap_read0");
    cyc(1'b0, 1'b1, 4'h0, 32'hFFFF_FC06, 32'h0, 32'h1122_3344, "wrap_hi_bits");
    cyc(1'b0, 1'b1, 4'h0, 32'd1023, 32'h0, 32'h0, "top_word");

    // Back-to-back traffic
    cyc(1'b0, 1'b1, 4'hF, 32'd3, 32'd7, 32'd7, "b2b_write3");
    cyc(1'b0, 1'b1, 4'hF, 32'd4, 32'd9, 32'd9, "b2b_write4");
    cyc(1'b0, 1'b1, 4'h0, 32'd3, 32'h0, 32'd7, "b2b_read3");
    cyc(1'b0, 1'b1, 4'h0, 32'd4, 32'h0, 32'd9, "b2b_read4");
    cyc(1'b0, 1'b1, 4'h0, 32'd3, 32'hFFFF_FFFF, 32'd7, "pure_read3");
    cyc(1'b0, 1'b1, 4'h0, 32'd4, 32'hFFFF_FFFF, 32'd9, "pure_read4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL set the number of word-address bits, giving a depth of 2^ADDR_BITS words.
REQ-002 Parameter DATA_BITS, default 32, SHALL set the word width; it SHALL be a multiple of 8.
REQ-003 clka  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rsta  input  1  SHALL be the synchronous, active-high reset.
REQ-005 ena  input  1  SHALL be the port enable; when low, no read or write occurs.
REQ-006 wea  input  DATA_BITS/8 (4)  SHALL be the per-byte write enables; bit i controls dina[8i+7:8i].
REQ-007 addra  input  32  SHALL be the word address; only bits [ADDR_BITS-1:0] are used.
REQ-008 dina  input  DATA_BITS  SHALL be the write data.
REQ-009 douta  output  DATA_BITS  SHALL be the registered read data.

Function
REQ-010 Storage SHALL be a single-port array of 2^ADDR_BITS words, all initialised to 0 at configuration/power-up.
REQ-011 Addressing SHALL be per word, not per byte: addra=N selects word N.
REQ-012 Address bits [31:ADDR_BITS] SHALL be ignored, so addresses wrap modulo 2^ADDR_BITS (1024 aliases 0 by default).
REQ-013 On a rising edge with ena=1, every byte lane i with wea[i]=1 SHALL be written from dina; lanes with wea[i]=0 SHALL keep their old contents.
REQ-014 Read latency SHALL be one clock: douta SHALL show the word at the address sampled on edge k from just after edge k.
REQ-015 The port SHALL be write-first: on a write edge, douta SHALL show the merged post-write word (new bytes in enabled lanes, old bytes elsewhere).
REQ-016 On a rising edge with ena=1 and wea all-zero, the edge SHALL be a pure read: douta updates and memory is unchanged.
REQ-017 On a rising edge with ena=0, memory and douta SHALL both hold their values, regardless of wea, addra and dina.
REQ-018 The design SHALL map to inferred block RAM with no combinational path from any input to douta.
REQ-019 A write followed by a read of the same address on the next edge SHALL return the written data; no hazard cycles are allowed.

Reset
REQ-020 With rsta=1 on a rising edge, douta SHALL become 0, taking priority over any read or write-first data.
REQ-021 Reset SHALL NOT clear the memory array; contents SHALL survive reset.
REQ-022 A write requested (ena=1, wea non-zero) on a reset edge SHALL still update the memory, while douta is forced to 0.
REQ-023 After rsta deasserts, the first edge with ena=1 SHALL resume normal read behaviour with no extra latency.

Verification
REQ-024 Full write then read: ena=1, wea=1111, addra=0, dina=54 for one edge, then wea=0000 -> douta=54 after the write edge and remains 54 on subsequent read edges.
REQ-025 Byte lanes: word 0 holds 0x00000036; write wea=0001, dina=0xFFFFFFAB -> word 0 reads 0x000000AB. Then write wea=1000, dina=0x12000000 -> word 0 reads 0x120000AB.
REQ-026 Enable gating: ena=0, wea=1111, addra=5, dina=0xDEADBEEF -> douta is unchanged. A later read of word 5 with ena=1 returns its prior value (0 after power-up).
REQ-027 Reset: word 0 holds 54 and douta=54; pulse rsta for one edge -> douta=0. The next read of address 0 returns 54, because contents are preserved.
REQ-028 Wrap-around: write 0xA5A5A5A5 to addra=1024 with default ADDR_BITS -> a read of addra=0 returns 0xA5A5A5A5.
REQ-029 Back-to-back traffic: write 7 to word 3 and 9 to word 4 on consecutive edges, then read 3 and 4 on consecutive edges -> douta shows 7, 9, 7, 9 on successive edges, each one cycle after its address.
